// File: rtl/neokeon_round_sequencer.sv
// Neokeon-128 round sequencer: owns the state/working-key registers, steps one round per clock
// through an external combinational round unit, and provides a start/valid handshake.
module neokeon_round_sequencer #(
  parameter int ROUNDS = 16,
  parameter int WIDTH  = 128
) (
  input  logic             inClk,
  input  logic             inRst,
  input  logic             inStart,
  input  logic             inDecrypt,
  input  logic [WIDTH-1:0] inKey,
  input  logic [WIDTH-1:0] inData,
  input  logic [WIDTH-1:0] inRoundResult,
  output logic [WIDTH-1:0] outRoundState,
  output logic [WIDTH-1:0] outRoundKey,
  output logic [7:0]       outRoundConst,
  output logic             outKeyPrep,
  output logic             outFinal,
  output logic             outReady,
  output logic             outBusy,
  output logic             outValid,
  output logic [WIDTH-1:0] outData
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_KEYPREP = 2'd1,
    S_ROUND   = 2'd2,
    S_FINAL   = 2'd3
  } state_e;

  state_e           fsm_q;
  logic [4:0]       cnt_q;
  logic [WIDTH-1:0] state_q;
  logic [WIDTH-1:0] key_q;
  logic [WIDTH-1:0] data_q;
  logic             dec_q;
  logic             valid_q;
  logic [4:0]       rc_idx;

  function automatic logic [7:0] rc_lookup(input logic [4:0] idx);
    logic [7:0] rc;
    case (idx)
      5'd0:    rc = 8'h80;
      5'd1:    rc = 8'h1B;
      5'd2:    rc = 8'h36;
      5'd3:    rc = 8'h6C;
      5'd4:    rc = 8'hD8;
      5'd5:    rc = 8'hAB;
      5'd6:    rc = 8'h4D;
      5'd7:    rc = 8'h9A;
      5'd8:    rc = 8'h2F;
      5'd9:    rc = 8'h5E;
      5'd10:   rc = 8'hBC;
      5'd11:   rc = 8'h63;
      5'd12:   rc = 8'hC6;
      5'd13:   rc = 8'h97;
      5'd14:   rc = 8'h35;
      5'd15:   rc = 8'h6A;
      5'd16:   rc = 8'hD4;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

  // Decryption walks the constant table backwards; the final half-round uses the opposite end.
  always_comb begin
    rc_idx = 5'd0;
    case (fsm_q)
      S_ROUND: rc_idx = dec_q ? (5'(ROUNDS) - cnt_q) : cnt_q;
      S_FINAL: rc_idx = dec_q ? 5'd0 : 5'(ROUNDS);
      default: rc_idx = 5'd0;
    endcase
  end

  assign outRoundConst = ((fsm_q == S_ROUND) || (fsm_q == S_FINAL)) ? rc_lookup(rc_idx) : 8'h00;
  assign outKeyPrep    = (fsm_q == S_KEYPREP);
  assign outFinal      = (fsm_q == S_FINAL);
  assign outReady      = (fsm_q == S_IDLE);
  assign outBusy       = (fsm_q != S_IDLE);
  assign outRoundState = state_q;
  assign outRoundKey   = key_q;
  assign outValid      = valid_q;
  assign outData       = data_q;

  always_ff @(posedge inClk) begin
    if (inRst) begin
      fsm_q   <= S_IDLE;
      cnt_q   <= 5'd0;
      state_q <= '0;
      key_q   <= '0;
      data_q  <= '0;
      dec_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (fsm_q)
        S_IDLE: begin
          if (inStart) begin
            state_q <= inData;
            key_q   <= inKey;
            dec_q   <= inDecrypt;
            cnt_q   <= 5'd0;
            fsm_q   <= inDecrypt ? S_KEYPREP : S_ROUND;
          end
        end
        S_KEYPREP: begin
          key_q <= inRoundResult;
          fsm_q <= S_ROUND;
        end
        S_ROUND: begin
          state_q <= inRoundResult;
          cnt_q   <= cnt_q + 5'd1;
          if (cnt_q == 5'(ROUNDS - 1)) begin
            fsm_q <= S_FINAL;
          end
        end
        S_FINAL: begin
          data_q  <= inRoundResult;
          valid_q <= 1'b1;
          fsm_q   <= S_IDLE;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neokeon_round_sequencer.sv
// Directed bench for neokeon_round_sequencer with a trivial round-unit model
// (state + 1 for rounds/final, key ^ 1 for key preparation).
module tb_neokeon_round_sequencer;

  logic         inClk = 1'b0;
  logic         inRst;
  logic         inStart;
  logic         inDecrypt;
  logic [127:0] inKey;
  logic [127:0] inData;
  logic [127:0] inRoundResult;
  logic [127:0] outRoundState;
  logic [127:0] outRoundKey;
  logic [7:0]   outRoundConst;
  logic         outKeyPrep;
  logic         outFinal;
  logic         outReady;
  logic         outBusy;
  logic         outValid;
  logic [127:0] outData;

  int n_assert = 0;
  int n_fail   = 0;
  logic [127:0] last_data;
  logic [7:0]   rc_tab [0:16] = '{8'h80, 8'h1B, 8'h36, 8'h6C, 8'hD8, 8'hAB, 8'h4D, 8'h9A, 8'h2F,
                                 8'h5E, 8'hBC, 8'h63, 8'hC6, 8'h97, 8'h35, 8'h6A, 8'hD4};

  always #5 inClk = ~inClk;

  assign inRoundResult = outKeyPrep ? (outRoundKey ^ 128'h1) : (outRoundState + 128'h1);

  neokeon_round_sequencer #(.ROUNDS(16), .WIDTH(128)) dut (
    .inClk(inClk), .inRst(inRst), .inStart(inStart), .inDecrypt(inDecrypt),
    .inKey(inKey), .inData(inData), .inRoundResult(inRoundResult),
    .outRoundState(outRoundState), .outRoundKey(outRoundKey), .outRoundConst(outRoundConst),
    .outKeyPrep(outKeyPrep), .outFinal(outFinal), .outReady(outReady), .outBusy(outBusy),
    .outValid(outValid), .outData(outData)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives the start, checks every cycle of the job and
  // returns at the negedge of the outValid cycle (an IDLE cycle).
  task automatic run_job(input logic dec, input logic [127:0] data, input int inject);
    logic [7:0] exp_c;
    inStart = 1'b1; inDecrypt = dec; inData = data; inKey = '0;
    @(negedge inClk);
    inStart = 1'b0; inDecrypt = ~dec; inData = '1; inKey = '1;
    if (dec) begin
      chk("keyprep_flag", 128'(outKeyPrep), 128'h1);
      chk("keyprep_key", outRoundKey, 128'h0);
      chk("keyprep_const", 128'(outRoundConst), 128'h0);
      chk("keyprep_busy", 128'(outBusy), 128'h1);
      @(negedge inClk);
    end
    for (int i = 0; i < 16; i++) begin
      exp_c = dec ? rc_tab[16 - i] : rc_tab[i];
      chk($sformatf("round%0d_const", i), 128'(outRoundConst), 128'(exp_c));
      chk($sformatf("round%0d_final", i), 128'(outFinal), 128'h0);
      chk($sformatf("round%0d_keyprep", i), 128'(outKeyPrep), 128'h0);
      chk($sformatf("round%0d_busy", i), 128'({outBusy, outReady}), 128'h2);
      chk($sformatf("round%0d_valid", i), 128'(outValid), 128'h0);
      chk($sformatf("round%0d_data_held", i), outData, last_data);
      chk($sformatf("round%0d_state", i), outRoundState, data + 128'(i));
      if (dec) chk($sformatf("round%0d_key", i), outRoundKey, 128'h1);
      if (i == inject) begin
        inStart = 1'b1; inData = 128'hDEAD_BEEF; inDecrypt = 1'b1;
      end
      @(negedge inClk);
      inStart = 1'b0;
    end
    chk("final_flag", 128'(outFinal), 128'h1);
    chk("final_const", 128'(outRoundConst), dec ? 128'h80 : 128'hD4);
    chk("final_valid", 128'(outValid), 128'h0);
    chk("final_state", outRoundState, data + 128'd16);
    @(negedge inClk);
    last_data = data + 128'd17;
    chk("valid_pulse", 128'(outValid), 128'h1);
    chk("valid_data", outData, last_data);
    chk("valid_ready", 128'({outReady, outBusy}), 128'h2);
    chk("valid_const", 128'(outRoundConst), 128'h0);
    $display("job dec=%0d data=%0h -> outData=%0h", dec, data, outData);
  endtask

  initial begin
    inRst = 1'b1; inStart = 1'b0; inDecrypt = 1'b0; inKey = '0; inData = '0;
    last_data = '0;
    repeat (2) @(negedge inClk);
    chk("rst_ready", 128'(outReady), 128'h1);
    chk("rst_busy", 128'(outBusy), 128'h0);
    chk("rst_valid", 128'(outValid), 128'h0);
    chk("rst_data", outData, 128'h0);
    chk("rst_state", outRoundState, 128'h0);
    chk("rst_key", outRoundKey, 128'h0);
    chk("rst_flags", 128'({outKeyPrep, outFinal}), 128'h0);
    chk("rst_const", 128'(outRoundConst), 128'h0);
    inRst = 1'b0;

    // Idle with no start: nothing happens for 50 cycles
    for (int i = 0; i < 50; i++) begin
      @(negedge inClk);
      chk("idle_ready", 128'(outReady), 128'h1);
      chk("idle_valid", 128'(outValid), 128'h0);
      chk("idle_const", 128'(outRoundConst), 128'h0);
    end
    $display("idle 50 cycles done");

    // Encrypt data=0
    run_job(1'b0, 128'h0, -1);
    @(negedge inClk);
    chk("enc_valid_drop", 128'(outValid), 128'h0);
    chk("enc_data_hold", outData, 128'h11);

    // Decrypt data=5
    run_job(1'b1, 128'h5, -1);
    chk("dec_result", outData, 128'h16);
    @(negedge inClk);
    chk("dec_valid_drop", 128'(outValid), 128'h0);

    // Start pulse during round 5 is ignored
    run_job(1'b0, 128'h0, 5);
    for (int i = 0; i < 20; i++) begin
      @(negedge inClk);
      chk("ignored_start_no_valid", 128'(outValid), 128'h0);
      chk("ignored_start_idle", 128'(outReady), 128'h1);
    end

    // Back-to-back: start issued in the outValid cycle
    run_job(1'b0, 128'h0, -1);
    run_job(1'b0, 128'h100, -1);
    chk("b2b_result", outData, 128'h111);
    @(negedge inClk);
    chk("b2b_valid_drop", 128'(outValid), 128'h0);

    // Reset in round 7 aborts the job
    inStart = 1'b1; inDecrypt = 1'b0; inData = 128'h0;
    @(negedge inClk);
    inStart = 1'b0;
    repeat (7) @(negedge inClk);
    chk("pre_abort_busy", 128'(outBusy), 128'h1);
    inRst = 1'b1;
    @(negedge inClk);
    inRst = 1'b0;
    last_data = '0;
    chk("abort_busy", 128'(outBusy), 128'h0);
    chk("abort_ready", 128'(outReady), 128'h1);
    chk("abort_valid", 128'(outValid), 128'h0);
    chk("abort_data", outData, 128'h0);
    for (int i = 0; i < 30; i++) begin
      @(negedge inClk);
      chk("abort_no_valid", 128'(outValid), 128'h0);
    end
    $display("abort check done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
